// File: rtl/fetch_controller_if.sv
// Fetch-side signal bundle: redirect/stall from the pipeline, imem handshake, delivered instruction.
// No storage; pure wiring between the fetch controller and its environment.
// Flow control is imem_req/imem_ready toward memory and stall from downstream.
interface fetch_controller_if #(
  parameter int ADDR_W = 5
);
  logic              stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic              instr_valid;
  logic [ADDR_W-1:0] instr_pc;
  logic [ADDR_W-1:0] pc;
  logic [7:0]        fetch_count;

  // Controller side
  modport master (
    input  stall, redirect_valid, redirect_pc, imem_ready,
    output imem_req, imem_addr, instr_valid, instr_pc, pc, fetch_count
  );

  // Pipeline / memory side
  modport slave (
    output stall, redirect_valid, redirect_pc, imem_ready,
    input  imem_req, imem_addr, instr_valid, instr_pc, pc, fetch_count
  );
endinterface

// File: rtl/fetch_controller.sv
// Sequential instruction fetcher with redirect handling and a one-deep pending-redirect slot.
// One cycle from imem_ready to instr_valid; back-to-back fetch sustains one instruction per ready cycle.
// stall is sampled only at completion and in STALLED; an outstanding request is never withdrawn by it.
module fetch_controller #(
  parameter int ADDR_W   = 5,
  parameter int STEP     = 4,
  parameter int RESET_PC = 0
) (
  input logic              clk,
  input logic              rst_n,
  fetch_controller_if.master bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] FETCH   = 2'd1;
  localparam logic [1:0] STALLED = 2'd2;

  localparam logic [ADDR_W-1:0] STEP_V  = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] RESET_V = ADDR_W'(RESET_PC);

  logic [1:0]        state, state_nxt;
  logic [ADDR_W-1:0] pc_q, pc_nxt;
  logic              pend, pend_nxt;
  logic [ADDR_W-1:0] pend_pc, pend_pc_nxt;
  logic              instr_valid_q, instr_valid_nxt;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_nxt;
  logic [7:0]        count_q, count_nxt;

  // Next-state and datapath decisions for every state
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc_q;
    pend_nxt        = pend;
    pend_pc_nxt     = pend_pc;
    instr_valid_nxt = 1'b0;
    instr_pc_nxt    = instr_pc_q;
    count_nxt       = count_q;

    case (state)
      IDLE: begin
        // Reset-only state; always moves on, taking any redirect with it
        state_nxt = FETCH;
        if (bus.redirect_valid) begin
          pc_nxt = bus.redirect_pc;
        end
      end

      FETCH: begin
        if (bus.imem_ready) begin
          // Request completes this cycle; the pending slot is always consumed
          pend_nxt  = 1'b0;
          state_nxt = FETCH;
          if (bus.redirect_valid) begin
            // Live redirect beats both the fetched word and any pending target
            pc_nxt = bus.redirect_pc;
          end else if (pend) begin
            // Word fetched from the stale path is dropped
            pc_nxt = pend_pc;
          end else begin
            instr_valid_nxt = 1'b1;
            instr_pc_nxt    = pc_q;
            pc_nxt          = pc_q + STEP_V;
            count_nxt       = count_q + 8'd1;
            state_nxt       = bus.stall ? STALLED : FETCH;
          end
        end else if (bus.redirect_valid) begin
          // Address must stay stable mid-request, so park the target; newest wins
          pend_nxt    = 1'b1;
          pend_pc_nxt = bus.redirect_pc;
        end
      end

      STALLED: begin
        if (bus.redirect_valid) begin
          pc_nxt    = bus.redirect_pc;
          state_nxt = FETCH;
        end else if (!bus.stall) begin
          state_nxt = FETCH;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // PC and pending-redirect registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_V;
      pend    <= 1'b0;
      pend_pc <= '0;
    end else begin
      pc_q    <= pc_nxt;
      pend    <= pend_nxt;
      pend_pc <= pend_pc_nxt;
    end
  end

  // Delivery pulse, delivered address and instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_valid_q <= 1'b0;
      instr_pc_q    <= '0;
      count_q       <= 8'd0;
    end else begin
      instr_valid_q <= instr_valid_nxt;
      instr_pc_q    <= instr_pc_nxt;
      count_q       <= count_nxt;
    end
  end

  // Outputs decode from registered state only; reset drops imem_req without a clock edge
  assign bus.imem_req    = (state == FETCH);
  assign bus.imem_addr   = pc_q;
  assign bus.pc          = pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.fetch_count = count_q;

  // The request address must not move while memory has not yet accepted it
  property p_addr_stable;
    @(posedge clk) disable iff (!rst_n)
      (bus.imem_req && !bus.imem_ready && !$past(!rst_n)) |=> $stable(bus.imem_addr);
  endproperty
  a_addr_stable: assert property (p_addr_stable);

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios plus randomized traffic vs a queue-based model.
// Inputs change on the falling edge; outputs are compared on the falling edge.
// Every wait is a fixed number of clock cycles, so the run always terminates.
module tb_fetch_controller;
  localparam int AW = 5;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  fetch_controller_if #(.ADDR_W(AW)) bus ();

  fetch_controller #(.ADDR_W(AW), .STEP(4), .RESET_PC(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what the fetcher should have done, in plain integers.
  // m_mode: 0 = just out of reset, 1 = requesting, 2 = holding for downstream.
  int m_mode;
  int m_pc;
  int m_count;
  int m_last_pc;
  bit m_valid;
  int m_redirq[$];   // at most one parked redirect target

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_count = 0; m_last_pc = 0; m_valid = 0;
    m_redirq.delete();
  endtask

  task automatic model_step(input bit s, input bit rv, input int rpc, input bit rdy);
    m_valid = 0;
    if (m_mode == 0) begin
      m_mode = 1;
      if (rv) m_pc = rpc;
    end else if (m_mode == 2) begin
      if (rv) begin m_pc = rpc; m_mode = 1; end
      else if (!s) m_mode = 1;
    end else if (rdy) begin
      if (rv) begin
        m_pc = rpc; m_redirq.delete();
      end else if (m_redirq.size() > 0) begin
        m_pc = m_redirq[0]; m_redirq.delete();
      end else begin
        m_valid   = 1;
        m_last_pc = m_pc;
        m_pc      = (m_pc + 4) % 32;
        m_count   = (m_count + 1) % 256;
        m_mode    = s ? 2 : 1;
      end
    end else if (rv) begin
      m_redirq.delete();
      m_redirq.push_back(rpc);
    end
  endtask

  // One clock: drive at the falling edge, model follows the rising edge, return at next falling edge
  task automatic tick(input bit s, input bit rv, input logic [AW-1:0] rpc, input bit rdy);
    bus.stall          = s;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.imem_ready     = rdy;
    @(posedge clk);
    model_step(s, rv, int'(rpc), rdy);
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.stall = 0; bus.redirect_valid = 0; bus.redirect_pc = '0; bus.imem_ready = 0;
    rst_n = 1'b0;
    #3;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (bus.imem_req !== 1'b0) $display("FAIL reset_req_idle: got %0b want 0", bus.imem_req); else n_pass++;
    n_total++; if (bus.pc !== 5'd0) $display("FAIL reset_pc: got %0d want 0", bus.pc); else n_pass++;
    n_total++; if (bus.fetch_count !== 8'd0) $display("FAIL reset_count: got %0d want 0", bus.fetch_count); else n_pass++;
    n_total++; if (bus.instr_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", bus.instr_valid); else n_pass++;
    tick(0, 1, 5'd16, 0);
    tick(0, 0, 5'd0, 0);
    n_total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 5'd16)
      $display("FAIL reset_prereq: req %0b addr %0d want 1/16", bus.imem_req, bus.imem_addr); else n_pass++;
    // Pull reset between edges: outputs must fall without a clock
    #2;
    rst_n = 1'b0;
    #1;
    n_total++; if (bus.imem_req !== 1'b0) $display("FAIL async_req: got %0b want 0", bus.imem_req); else n_pass++;
    n_total++; if (bus.pc !== 5'd0 || bus.instr_pc !== 5'd0)
      $display("FAIL async_pc: pc %0d instr_pc %0d want 0/0", bus.pc, bus.instr_pc); else n_pass++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    n_total++; if (bus.imem_req !== 1'b0) $display("FAIL release_idle: got %0b want 0", bus.imem_req); else n_pass++;
    tick(0, 0, 5'd0, 1);
    n_total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 5'd0 || bus.instr_valid !== 1'b0)
      $display("FAIL refetch_zero: req %0b addr %0d valid %0b want 1/0/0", bus.imem_req, bus.imem_addr, bus.instr_valid); else n_pass++;
  endtask

  task automatic test_sequential();
    do_reset();
    tick(0, 0, 5'd0, 1);
    n_total++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1)
      $display("FAIL seq_first: valid %0b req %0b want 0/1", bus.instr_valid, bus.imem_req); else n_pass++;
    for (int k = 0; k < 9; k++) begin
      tick(0, 0, 5'd0, 1);
      n_total++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 5'((k * 4) % 32))
        $display("FAIL seq_pc[%0d]: valid %0b pc %0d want 1/%0d", k, bus.instr_valid, bus.instr_pc, (k * 4) % 32); else n_pass++;
      n_total++; if (bus.fetch_count !== 8'(k + 1))
        $display("FAIL seq_count[%0d]: got %0d want %0d", k, bus.fetch_count, k + 1); else n_pass++;
    end
  endtask

  task automatic test_stall();
    do_reset();
    tick(0, 1, 5'd8, 0);
    tick(1, 0, 5'd0, 1);
    n_total++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 5'd8)
      $display("FAIL stall_deliver: valid %0b pc %0d want 1/8", bus.instr_valid, bus.instr_pc); else n_pass++;
    n_total++; if (bus.imem_req !== 1'b0 || bus.pc !== 5'd12)
      $display("FAIL stall_enter: req %0b pc %0d want 0/12", bus.imem_req, bus.pc); else n_pass++;
    tick(1, 0, 5'd0, 1);
    n_total++; if (bus.imem_req !== 1'b0 || bus.pc !== 5'd12 || bus.instr_valid !== 1'b0 || bus.fetch_count !== 8'd1)
      $display("FAIL stall_hold: req %0b pc %0d valid %0b cnt %0d want 0/12/0/1", bus.imem_req, bus.pc, bus.instr_valid, bus.fetch_count); else n_pass++;
    tick(0, 0, 5'd0, 0);
    n_total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 5'd12)
      $display("FAIL stall_resume: req %0b addr %0d want 1/12", bus.imem_req, bus.imem_addr); else n_pass++;
    tick(0, 0, 5'd0, 1);
    n_total++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 5'd12)
      $display("FAIL stall_after: valid %0b pc %0d want 1/12", bus.instr_valid, bus.instr_pc); else n_pass++;
  endtask

  task automatic test_pending_redirect();
    do_reset();
    tick(0, 1, 5'd4, 0);
    tick(0, 1, 5'd20, 0);
    n_total++; if (bus.imem_addr !== 5'd4 || bus.imem_req !== 1'b1)
      $display("FAIL pend_hold1: addr %0d req %0b want 4/1", bus.imem_addr, bus.imem_req); else n_pass++;
    tick(1, 0, 5'd0, 0);
    tick(0, 0, 5'd0, 0);
    n_total++; if (bus.imem_addr !== 5'd4) $display("FAIL pend_hold3: got %0d want 4", bus.imem_addr); else n_pass++;
    tick(0, 0, 5'd0, 1);
    n_total++; if (bus.instr_valid !== 1'b0 || bus.fetch_count !== 8'd0 || bus.imem_addr !== 5'd20)
      $display("FAIL pend_discard: valid %0b cnt %0d addr %0d want 0/0/20", bus.instr_valid, bus.fetch_count, bus.imem_addr); else n_pass++;
    tick(0, 0, 5'd0, 1);
    n_total++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 5'd20 || bus.fetch_count !== 8'd1)
      $display("FAIL pend_target: valid %0b pc %0d cnt %0d want 1/20/1", bus.instr_valid, bus.instr_pc, bus.fetch_count); else n_pass++;
  endtask

  task automatic test_newest_wins();
    do_reset();
    tick(0, 1, 5'd4, 0);
    tick(0, 1, 5'd20, 0);
    tick(0, 1, 5'd16, 0);
    n_total++; if (bus.imem_addr !== 5'd4) $display("FAIL newest_hold: got %0d want 4", bus.imem_addr); else n_pass++;
    tick(0, 0, 5'd0, 1);
    n_total++; if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 5'd16)
      $display("FAIL newest_redir: valid %0b addr %0d want 0/16", bus.instr_valid, bus.imem_addr); else n_pass++;
    tick(0, 0, 5'd0, 1);
    n_total++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 5'd16 || bus.fetch_count !== 8'd1)
      $display("FAIL newest_one_discard: valid %0b pc %0d cnt %0d want 1/16/1", bus.instr_valid, bus.instr_pc, bus.fetch_count); else n_pass++;
  endtask

  task automatic test_redirect_at_completion();
    do_reset();
    tick(0, 1, 5'd8, 0);
    tick(0, 1, 5'd12, 1);
    n_total++; if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 5'd12 || bus.fetch_count !== 8'd0)
      $display("FAIL redir_complete: valid %0b addr %0d cnt %0d want 0/12/0", bus.instr_valid, bus.imem_addr, bus.fetch_count); else n_pass++;
    // Redirect also overrides stall at completion
    tick(1, 1, 5'd24, 1);
    n_total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 5'd24)
      $display("FAIL redir_over_stall: req %0b addr %0d want 1/24", bus.imem_req, bus.imem_addr); else n_pass++;
  endtask

  task automatic test_count_wrap();
    do_reset();
    tick(0, 0, 5'd0, 1);
    for (int k = 0; k < 255; k++) tick(0, 0, 5'd0, 1);
    n_total++; if (bus.fetch_count !== 8'd255) $display("FAIL count_255: got %0d want 255", bus.fetch_count); else n_pass++;
    tick(0, 0, 5'd0, 1);
    n_total++; if (bus.fetch_count !== 8'd0 || bus.instr_pc !== 5'd28)
      $display("FAIL count_wrap: cnt %0d pc %0d want 0/28", bus.fetch_count, bus.instr_pc); else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      tick(($urandom % 4) == 0, ($urandom % 6) == 0, 5'($urandom), $urandom_range(0, 1) == 1);
      n_total++; if (bus.imem_req !== (m_mode == 1))
        $display("FAIL rnd_req[%0d]: got %0b want %0b", c, bus.imem_req, m_mode == 1); else n_pass++;
      n_total++; if (bus.imem_addr !== 5'(m_pc) || bus.pc !== 5'(m_pc))
        $display("FAIL rnd_pc[%0d]: addr %0d pc %0d want %0d", c, bus.imem_addr, bus.pc, m_pc); else n_pass++;
      n_total++; if (bus.instr_valid !== m_valid)
        $display("FAIL rnd_valid[%0d]: got %0b want %0b", c, bus.instr_valid, m_valid); else n_pass++;
      n_total++; if (bus.instr_pc !== 5'(m_last_pc))
        $display("FAIL rnd_instr_pc[%0d]: got %0d want %0d", c, bus.instr_pc, m_last_pc); else n_pass++;
      n_total++; if (bus.fetch_count !== 8'(m_count))
        $display("FAIL rnd_count[%0d]: got %0d want %0d", c, bus.fetch_count, m_count); else n_pass++;
    end
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    bus.stall = 0; bus.redirect_valid = 0; bus.redirect_pc = '0; bus.imem_ready = 0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_sequential();
    test_stall();
    test_pending_redirect();
    test_newest_wins();
    test_redirect_at_completion();
    test_count_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter ADDR_W, default 5, PC and instruction-address width in bits.
REQ-002 Parameter STEP, default 4, byte increment per sequential fetch.
REQ-003 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 stall  input  1  downstream cannot accept a further instruction.
REQ-007 redirect_valid  input  1  branch/jump taken this cycle.
REQ-008 redirect_pc  input  ADDR_W  branch/jump target.
REQ-009 imem_req  output  1  instruction-memory request.
REQ-010 imem_addr  output  ADDR_W  request address; equals pc.
REQ-011 imem_ready  input  1  memory completes the request this cycle; ignored when imem_req=0.
REQ-012 instr_valid  output  1  one-cycle pulse: a fetched instruction is delivered.
REQ-013 instr_pc  output  ADDR_W  address of the delivered instruction.
REQ-014 pc  output  ADDR_W  current fetch PC.
REQ-015 fetch_count  output  8  count of delivered instructions.

Function
REQ-016 States: IDLE, FETCH, STALLED; state is registered, and outputs decode from registered state only.
REQ-017 IDLE is entered only from reset; IDLE -> FETCH unconditionally on the next edge.
REQ-018 In FETCH, imem_req=1 and imem_addr=pc; in IDLE and STALLED, imem_req=0.
REQ-019 While imem_req=1 and imem_ready=0, imem_addr holds stable.
REQ-020 Completion in FETCH (imem_ready=1, no redirect this cycle, none pending): instr_valid<=1, instr_pc<=pc, pc<=pc+STEP, fetch_count<=fetch_count+1.
REQ-021 State after a REQ-020 completion: STALLED if stall=1 that cycle, else FETCH (back-to-back fetch, one instruction per ready cycle).
REQ-022 STALLED -> FETCH on the first edge with stall=0; pc is unchanged while STALLED.
REQ-023 instr_valid is high for exactly one cycle per completion; otherwise 0. instr_pc holds its last value.
REQ-024 PC arithmetic is modulo 2^ADDR_W (ADDR_W=5: 28+4 -> 0); fetch_count wraps 255 -> 0.
REQ-025 Redirect in IDLE or STALLED, or in FETCH together with imem_ready=1: pc<=redirect_pc, next state FETCH, no instr_valid, fetch_count unchanged; redirect overrides stall.
REQ-026 Redirect in FETCH with imem_ready=0: latch redirect_pc into a pending register, set pend flag, keep imem_addr unchanged.
REQ-027 While pend=1, a further redirect overwrites the pending target (newest wins).
REQ-028 Completion with pend=1: discard the instruction (no instr_valid, no count), pc<=pending target, clear pend, state FETCH.
REQ-029 Redirect and pend in the same completion cycle: redirect_pc wins, pend clears.
REQ-030 stall has no effect on an outstanding request; stall is evaluated only at completion and in STALLED.

Reset
REQ-031 When rst_n=0, immediately (asynchronously): state=IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, instr_pc=0, fetch_count=0, pend=0.
REQ-032 Assertion mid-request abandons the request; no instruction is delivered for it.
REQ-033 After rst_n rises, the first imem_req appears on the second edge (IDLE, then FETCH).

Verification
REQ-034 Reset release, imem_ready held 1, stall=0 -> instr_pc sequence 0,4,8,...,28,0 on consecutive cycles; fetch_count increments each cycle.
REQ-035 pc=8, imem_ready=1 with stall=1 -> instr_valid for pc 8; STALLED with imem_req=0 and pc=12 held; stall=0 -> fetch resumes at 12.
REQ-036 Request at pc=4 with imem_ready=0 for 3 cycles; redirect to 20 in cycle 1 -> imem_addr stays 4; completion discarded; next request at 20.
REQ-037 Pending redirect to 20, then redirect to 16 before completion -> next request at 16; only one discard.
REQ-038 Redirect to 12 in the same cycle as imem_ready at pc=8 -> no instr_valid; next imem_addr=12; fetch_count unchanged.
REQ-039 rst_n pulsed low mid-request at pc=16 -> imem_req drops without a clock edge; outputs at reset values; refetch starts at 0.
